// File: rtl/pipeline_result_collector_pkg.sv
// Shared state encoding and default widths for the pipeline result collector.
package pipeline_result_collector_pkg;

  typedef enum logic [1:0] {
    ACCUMULATE = 2'd0,
    DRAIN      = 2'd1,
    PRESENT    = 2'd2
  } state_t;

  localparam int ADDR_WIDTH            = 9;
  localparam int RESULT_WIDTH_DEF      = 40;
  localparam int SUM_WIDTH_DEF         = 64;
  localparam int OUTSTANDING_WIDTH_DEF = ADDR_WIDTH + 1;

endpackage

// File: rtl/pipeline_result_collector_outstanding_tracker.sv
// Saturating up/down counter: holds at all-ones on increment and at zero on decrement.
module outstanding_tracker #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             zero_next,
  output logic             underflow
);

  logic [WIDTH-1:0] count_next;

  assign full      = &count;
  assign underflow = dec && !inc && (count == '0);

  always_comb begin
    count_next = count;
    if (inc && !dec && !full) begin
      count_next = count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count_next = count - 1'b1;
    end
  end

  assign zero_next = (count_next == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/pipeline_result_collector.sv
// Accumulates per-bot pipeline results into one sum per job and presents it via valid/ready.
// Optional jobBotCount output is enabled by PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN.
//
// state      | meaning
// ACCUMULATE | accepting bots, summing results as they arrive
// DRAIN      | last bot of job accepted, waiting for remaining results
// PRESENT    | job sum presented, waiting for jobSumReady
module pipeline_result_collector
  import pipeline_result_collector_pkg::*;
#(
  parameter int RESULT_WIDTH      = RESULT_WIDTH_DEF,
  parameter int SUM_WIDTH         = SUM_WIDTH_DEF,
  parameter int OUTSTANDING_WIDTH = OUTSTANDING_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         botAccepted,
  input  logic                         lastBotOfJob,
  output logic                         acceptingBots,
  input  logic                         resultValid,
  input  logic [RESULT_WIDTH-1:0]      resultIn,
  output logic                         jobSumValid,
  input  logic                         jobSumReady,
  output logic [SUM_WIDTH-1:0]         jobSum,
`ifdef PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN
  output logic [31:0]                  jobBotCount,
`endif
  output logic [OUTSTANDING_WIDTH-1:0] outstandingCount,
  output logic                         protocolError
);

  state_t               state, state_next;
  logic [SUM_WIDTH-1:0] sum, sum_next;
  logic                 out_full, out_zero_next, out_underflow;
  logic                 handshake, sum_add, finish_job;

  outstanding_tracker #(.WIDTH(OUTSTANDING_WIDTH)) u_outstanding (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .inc       (botAccepted),
    .dec       (resultValid),
    .count     (outstandingCount),
    .full      (out_full),
    .zero_next (out_zero_next),
    .underflow (out_underflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUMULATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUMULATE: if (botAccepted && lastBotOfJob) state_next = DRAIN;
      DRAIN:      if (out_zero_next)               state_next = PRESENT;
      PRESENT:    if (jobSumReady)                 state_next = ACCUMULATE;
      default:                                     state_next = ACCUMULATE;
    endcase
  end

  always_comb begin
    acceptingBots = (state == ACCUMULATE) && !out_full;
    jobSumValid   = (state == PRESENT);
    handshake     = jobSumValid && jobSumReady;
    finish_job    = (state == DRAIN) && out_zero_next;
  end

  // Results landing while a sum is presented are dropped rather than folded into the next job.
  assign sum_add  = resultValid && (state != PRESENT);
  assign sum_next = sum + SUM_WIDTH'(resultIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (handshake) begin
      sum <= '0;
    end else if (sum_add) begin
      sum <= sum_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobSum <= '0;
    end else if (finish_job) begin
      jobSum <= sum_add ? sum_next : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocolError <= 1'b0;
    end else if (out_underflow || (botAccepted && !acceptingBots) ||
                 (resultValid && (state == PRESENT))) begin
      protocolError <= 1'b1;
    end
  end

`ifdef PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN
  logic [31:0] bot_count;
  logic        bot_unused_full, bot_unused_zero, bot_unused_uflow;

  outstanding_tracker #(.WIDTH(32)) u_bot_count (
    .clk       (clk),
    .rst       (rst),
    .clear     (handshake),
    .inc       (botAccepted),
    .dec       (1'b0),
    .count     (bot_count),
    .full      (bot_unused_full),
    .zero_next (bot_unused_zero),
    .underflow (bot_unused_uflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobBotCount <= '0;
    end else if (handshake) begin
      jobBotCount <= '0;
    end else if (finish_job) begin
      jobBotCount <= bot_count;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Directed table-driven bench for pipeline_result_collector plus multi-cycle corner sequences.
module tb_pipeline_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        botAccepted = 1'b0;
  logic        lastBotOfJob = 1'b0;
  logic        acceptingBots;
  logic        resultValid = 1'b0;
  logic [39:0] resultIn = '0;
  logic        jobSumValid;
  logic        jobSumReady = 1'b0;
  logic [63:0] jobSum;
  logic [9:0]  outstandingCount;
  logic        protocolError;
`ifdef PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN
  logic [31:0] jobBotCount;
`endif

  pipeline_result_collector dut (
    .clk              (clk),
    .rst              (rst),
    .botAccepted      (botAccepted),
    .lastBotOfJob     (lastBotOfJob),
    .acceptingBots    (acceptingBots),
    .resultValid      (resultValid),
    .resultIn         (resultIn),
    .jobSumValid      (jobSumValid),
    .jobSumReady      (jobSumReady),
    .jobSum           (jobSum),
`ifdef PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN
    .jobBotCount      (jobBotCount),
`endif
    .outstandingCount (outstandingCount),
    .protocolError    (protocolError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, bot, last, rv;
    logic [39:0] res;
    logic        rdy;
    logic        acc, valid;
    logic [63:0] sum;
    logic [9:0]  outs;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add_v(input logic r, b, l, v, input logic [39:0] res, input logic rdy,
                       input logic acc, valid, input logic [63:0] sum,
                       input logic [9:0] o, input logic e);
    vec_t t;
    t = '{r, b, l, v, res, rdy, acc, valid, sum, o, e};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b, l, v, input logic [39:0] res, input logic rdy);
    @(negedge clk);
    botAccepted  = b;
    lastBotOfJob = l;
    resultValid  = v;
    resultIn     = res;
    jobSumReady  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //     rst bot lst rv  res  rdy | acc val sum  out err
    add_v(1, 0, 0, 0, 0,   0,   1, 0, 0,   0, 0);
    add_v(0, 0, 0, 0, 0,   0,   1, 0, 0,   0, 0);
    add_v(0, 1, 0, 0, 0,   0,   1, 0, 0,   1, 0);
    add_v(0, 1, 0, 0, 0,   0,   1, 0, 0,   2, 0);
    add_v(0, 1, 1, 0, 0,   0,   0, 0, 0,   3, 0);
    add_v(0, 0, 0, 1, 5,   0,   0, 0, 0,   2, 0);
    add_v(0, 0, 0, 1, 7,   0,   0, 0, 0,   1, 0);
    add_v(0, 0, 0, 1, 11,  0,   0, 1, 23,  0, 0);
    add_v(0, 0, 0, 0, 0,   1,   1, 0, 23,  0, 0);
    for (int i = 1; i <= 4; i++) add_v(0, 1, 0, 0, 0, 0, 1, 0, 23, 10'(i), 0);
    add_v(0, 1, 0, 1, 100, 0,   1, 0, 23,  4, 0);
    add_v(0, 1, 1, 1, 3,   0,   0, 0, 23,  4, 0);
    add_v(0, 0, 0, 1, 1,   0,   0, 0, 23,  3, 0);
    add_v(0, 0, 0, 1, 1,   0,   0, 0, 23,  2, 0);
    add_v(0, 0, 0, 1, 1,   0,   0, 0, 23,  1, 0);
    add_v(0, 0, 0, 1, 1,   0,   0, 1, 107, 0, 0);
    for (int i = 0; i < 10; i++) add_v(0, 0, 0, 0, 0, 0, 0, 1, 107, 0, 0);
    add_v(0, 0, 0, 0, 0,   1,   1, 0, 107, 0, 0);
    add_v(0, 1, 1, 0, 0,   0,   0, 0, 107, 1, 0);
    add_v(0, 0, 0, 1, 9,   0,   0, 1, 9,   0, 0);
    add_v(0, 0, 0, 0, 0,   1,   1, 0, 9,   0, 0);
    add_v(0, 0, 0, 1, 4,   0,   1, 0, 9,   0, 1);
    add_v(0, 0, 0, 0, 0,   0,   1, 0, 9,   0, 1);
    for (int i = 1; i <= 5; i++) add_v(0, 1, 0, 0, 0, 0, 1, 0, 9, 10'(i), 1);
    add_v(0, 1, 1, 0, 0,   0,   0, 0, 9,   6, 1);
    add_v(1, 0, 0, 0, 0,   0,   1, 0, 0,   0, 0);
    add_v(0, 0, 0, 0, 0,   0,   1, 0, 0,   0, 0);
    add_v(0, 1, 1, 0, 0,   0,   0, 0, 0,   1, 0);
    add_v(0, 1, 0, 0, 0,   0,   0, 0, 0,   2, 1);
    add_v(0, 0, 0, 1, 2,   0,   0, 0, 0,   1, 1);
    add_v(0, 0, 0, 1, 3,   0,   0, 1, 5,   0, 1);
    add_v(0, 0, 0, 1, 50,  0,   0, 1, 5,   0, 1);
    add_v(0, 0, 0, 0, 0,   1,   1, 0, 5,   0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      botAccepted  = vecs[i].bot;
      lastBotOfJob = vecs[i].last;
      resultValid  = vecs[i].rv;
      resultIn     = vecs[i].res;
      jobSumReady  = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d acceptingBots", i), 64'(acceptingBots), 64'(vecs[i].acc));
      check($sformatf("vec%0d jobSumValid", i), 64'(jobSumValid), 64'(vecs[i].valid));
      check($sformatf("vec%0d jobSum", i), jobSum, vecs[i].sum);
      check($sformatf("vec%0d outstandingCount", i), 64'(outstandingCount), 64'(vecs[i].outs));
      check($sformatf("vec%0d protocolError", i), 64'(protocolError), 64'(vecs[i].err));
    end

    // Fill the in-flight counter to all-ones and back off by one.
    do_reset();
    for (int i = 0; i < 1022; i++) step(1, 0, 0, 0, 0);
    check("fill1022 outstanding", 64'(outstandingCount), 64'd1022);
    check("fill1022 acceptingBots", 64'(acceptingBots), 64'd1);
    step(1, 0, 0, 0, 0);
    check("fill1023 outstanding", 64'(outstandingCount), 64'd1023);
    check("fill1023 acceptingBots", 64'(acceptingBots), 64'd0);
    check("fill1023 protocolError", 64'(protocolError), 64'd0);
    step(0, 0, 1, 1, 0);
    check("drain1022 outstanding", 64'(outstandingCount), 64'd1022);
    check("drain1022 acceptingBots", 64'(acceptingBots), 64'd1);

    // Reset asserted mid-cycle while draining must act without a clock edge.
    do_reset();
    step(0, 0, 1, 0, 0);
    check("underflow protocolError", 64'(protocolError), 64'd1);
    check("underflow outstanding", 64'(outstandingCount), 64'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("drain6 outstanding", 64'(outstandingCount), 64'd6);
    check("drain6 acceptingBots", 64'(acceptingBots), 64'd0);
    @(negedge clk);
    botAccepted  = 1'b0;
    lastBotOfJob = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst outstanding", 64'(outstandingCount), 64'd0);
    check("async rst acceptingBots", 64'(acceptingBots), 64'd1);
    check("async rst jobSumValid", 64'(jobSumValid), 64'd0);
    check("async rst protocolError", 64'(protocolError), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three-bot job reported with its bot count.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 7, 0);
    step(0, 0, 1, 11, 0);
    check("job3 jobSum", jobSum, 64'd23);
    check("job3 jobSumValid", 64'(jobSumValid), 64'd1);
`ifdef PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN
    check("job3 jobBotCount", 64'(jobBotCount), 64'd3);
`endif
    step(0, 0, 0, 0, 1);
    check("job3 handshake jobSumValid", 64'(jobSumValid), 64'd0);
`ifdef PIPELINE_RESULT_COLLECTOR_BOT_COUNT_EN
    check("job3 handshake jobBotCount", 64'(jobBotCount), 64'd0);
`endif
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
